// File: rtl/grid_move_engine.sv
// grid_move_engine: 4x4 tile board move sequencer; optional tile spawn via GRID_SPAWN_EN
module grid_move_engine (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_dir,
  output logic        cmd_ready,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [15:0] wr_data,
  input  logic        clr,
  output logic [15:0] grid [16],
  output logic        busy,
  output logic        done,
  output logic        moved,
  output logic [19:0] score_delta,
  output logic [1:0]  win_lose
);
  typedef enum logic [2:0] {
    IDLE, LOAD, MERGE, STORE,
`ifdef GRID_SPAWN_EN
    SPAWN,
`endif
    CHECK, DONE
  } state_t;
  state_t state, nxt;
  logic [1:0]  dir, line;
  logic [15:0] lbuf [4];
  logic [15:0] c [5];
  logic [15:0] mrg [4];
  logic [19:0] msum;
  logic [2:0]  n;
  logic [1:0]  k;
  logic        skip, diff, lose, win;
  logic [3:0]  cidx [4];
  logic        accept;
  assign accept = (state == IDLE) && cmd_valid && !clr;
  // state register
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else       state <= nxt;
  // next-state sequencing: three cycles per line, then status check
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = accept ? LOAD : IDLE;
      LOAD:  nxt = MERGE;
      MERGE: nxt = STORE;
`ifdef GRID_SPAWN_EN
      STORE: nxt = (line == 2'd3) ? SPAWN : LOAD;
      SPAWN: nxt = CHECK;
`else
      STORE: nxt = (line == 2'd3) ? CHECK : LOAD;
`endif
      CHECK: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // handshake outputs
  always_comb begin
    cmd_ready = state == IDLE;
    busy      = state != IDLE;
    done      = state == DONE;
  end
  // cell indices of the current line, ordered so index 0 is the slide target
  always_comb
    for (int j = 0; j < 4; j++)
      cidx[j] = dir == 2'd0 ? {line, 2'(j)} : dir == 2'd1 ? {line, 2'(3 - j)} :
                dir == 2'd2 ? {2'(j), line} : {2'(3 - j), line};
  // shared merge datapath: compress, then merge pairs left to right once each
  always_comb begin
    for (int i = 0; i < 5; i++) c[i] = '0;
    for (int i = 0; i < 4; i++) mrg[i] = '0;
    msum = '0;
    n = '0;
    k = '0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++)
      if (lbuf[i] != 16'd0) begin
        c[n] = lbuf[i];
        n = n + 3'd1;
      end
    for (int i = 0; i < 4; i++)
      if (skip) skip = 1'b0;
      else if (c[i] != 16'd0 && c[i] == c[i+1] && c[i] != 16'h8000) begin
        mrg[k] = {c[i][14:0], 1'b0};
        msum = msum + 20'({c[i], 1'b0});
        k = k + 2'd1;
        skip = 1'b1;
      end else if (c[i] != 16'd0) begin
        mrg[k] = c[i];
        k = k + 2'd1;
      end
  end
  // board status: change detect for the stored line, win tile, stuck board
  always_comb begin
    diff = 1'b0;
    win = 1'b0;
    lose = 1'b1;
    for (int j = 0; j < 4; j++) diff = diff | (grid[cidx[j]] != lbuf[j]);
    for (int i = 0; i < 16; i++) begin
      win = win | (grid[i] >= 16'h0800);
      lose = lose & (grid[i] != 16'd0);
    end
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 3; q++) begin
        lose = lose & (grid[r*4+q] != grid[r*4+q+1]);
        lose = lose & (grid[q*4+r] != grid[q*4+r+4]);
      end
  end
`ifdef GRID_SPAWN_EN
  logic [15:0] lfsr;
  logic [3:0]  sel, p;
  logic        found;
  // free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge Clk)
    if (Reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // first empty cell at or after the random start, wrapping; lowest offset wins
  always_comb begin
    found = 1'b0;
    sel = '0;
    p = '0;
    for (int q = 15; q >= 0; q--) begin
      p = lfsr[3:0] + 4'(q);
      if (grid[p] == 16'd0) begin
        found = 1'b1;
        sel = p;
      end
    end
  end
`endif
  // grid, line buffer, accumulators and status registers
  always_ff @(posedge Clk)
    if (Reset) begin
      for (int i = 0; i < 16; i++) grid[i] <= '0;
      for (int j = 0; j < 4; j++) lbuf[j] <= '0;
      dir <= '0;
      line <= '0;
      moved <= 1'b0;
      score_delta <= '0;
      win_lose <= '0;
    end else
      case (state)
        IDLE:
          if (clr) begin
            for (int i = 0; i < 16; i++) grid[i] <= '0;
            win_lose <= '0;
          end else begin
            if (wr_en) grid[wr_idx] <= wr_data;
            win_lose[1] <= lose;
            if (cmd_valid) begin
              dir <= cmd_dir;
              line <= '0;
              moved <= 1'b0;
              score_delta <= '0;
            end
          end
        LOAD:
          for (int j = 0; j < 4; j++) lbuf[j] <= grid[cidx[j]];
        MERGE: begin
          for (int j = 0; j < 4; j++) lbuf[j] <= mrg[j];
          score_delta <= score_delta + msum;
        end
        STORE: begin
          for (int j = 0; j < 4; j++) grid[cidx[j]] <= lbuf[j];
          moved <= moved | diff;
          line <= line + 2'd1;
        end
`ifdef GRID_SPAWN_EN
        SPAWN:
          if (moved && found) grid[sel] <= (lfsr[7:4] == 4'd0) ? 16'd4 : 16'd2;
`endif
        CHECK:
          win_lose <= {lose, win_lose[0] | win};
        default: ;
      endcase
endmodule

// File: doc/grid_move_engine.md
# grid_move_engine

Hardware move sequencer for the 4x4 tile game board. It holds the 16 grid registers that feed the image mapper and accepts one direction command at a time. It slides and merges the four lines through a single shared merge datapath, then reports the moved flag, score delta and win/lose status. It replaces the per-move grid recomputation in Nios software; software only issues commands and loads or clears the board.

## Interface
- No parameters; geometry is fixed at 4x4 cells of 16-bit tile values. Tile values: 0 = empty, otherwise a power of two.
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high; clears all state
- cmd_valid  in  1  move request
- cmd_dir  in  2  direction: 0 = left, 1 = right, 2 = up, 3 = down
- cmd_ready  out  1  high only in IDLE
- wr_en  in  1  software cell write; honoured only in IDLE
- wr_idx  in  4  cell index, row*4+col
- wr_data  in  16  cell value
- clr  in  1  zero the grid and clear win_lose; honoured only in IDLE; has priority over wr_en and cmd
- grid  out  16x16  cell values, unpacked array indexed row*4+col
- busy  out  1  high whenever not in IDLE
- done  out  1  one-cycle pulse at the end of a move
- moved  out  1  a cell changed during the last move; valid with done, held until the next accept
- score_delta  out  20  sum of merged tile values for the last move; held like moved
- win_lose  out  2  bit0 = win (sticky), bit1 = lose

## Operation
- States: IDLE, LOAD, MERGE, STORE, [SPAWN], CHECK, DONE.
- In IDLE, a cycle with cmd_valid && cmd_ready latches cmd_dir, sets line = 0, clears the moved and score accumulators, and goes to LOAD.
- LOAD: copy line `line` into a 4-entry line buffer, ordered by direction:
  - left: row `line`, cols 0..3
  - right: row `line`, cols 3..0
  - up: col `line`, rows 0..3
  - down: col `line`, rows 3..0
- MERGE: the shared datapath transforms the buffer.
  - Compress nonzero entries toward index 0.
  - Merge adjacent equal nonzero pairs from index 0 upward; each tile merges at most once.
  - A pair of 16'h8000 does not merge (no overflow).
  - Each merge result is added to the score accumulator.
- STORE: write the buffer back to the same cells and OR "any cell differs" into moved. If line == 3, go on; otherwise increment line and return to LOAD.
- SPAWN (only with the macro enabled): see Configuration.
- CHECK:
  - Set win_lose[0] if any cell is ≥ 16'h0800; it stays set until Reset or clr.
  - Set win_lose[1] if no cell is empty and no horizontally or vertically adjacent cells are equal; otherwise clear it.
- DONE: pulse done, drive moved and score_delta, return to IDLE.
- Worked merges: [2,2,2,2] becomes [4,4,0,0] with delta 8. [2,0,2,4] becomes [4,4,0,0] with delta 4. [4,2,2,0] becomes [4,4,0,0], not [8,...].
- clr and wr_en in IDLE take effect at the next edge; win_lose[1] is recomputed from the new grid one cycle later.
- A cmd_valid, wr_en or clr arriving while busy is ignored. Requesters must hold cmd_valid until they see cmd_ready.

## Timing
- Reset values:
  - grid all 0
  - state IDLE; cmd_ready = 1
  - busy = 0, done = 0, moved = 0, score_delta = 0, win_lose = 2'b00
  - LFSR = 16'hACE1
- Acceptance edge is cycle 0. LOAD/MERGE/STORE for line n occupy cycles 3n+1..3n+3, so lines finish by cycle 12.
- CHECK is cycle 13 and done is high in cycle 14 (SPAWN enabled: SPAWN cycle 13, CHECK 14, done 15).
- cmd_ready returns high in the cycle after done, so back-to-back moves start every 15 (16) cycles.
- grid outputs change only on STORE/SPAWN/wr/clr edges.
- The mapper samples grid asynchronously to the move sequence, so mid-move frames may show partial updates; this is accepted.
- Reset mid-move aborts immediately to reset values with no partial write-back.

## Configuration
- GRID_SPAWN_EN defined:
  - A free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - In SPAWN, if moved == 1, place a tile in the first empty cell at or after index lfsr[3:0], wrapping 15→0.
  - The tile value is 4 if lfsr[7:4] == 0, else 2.
  - If moved == 0 or no cell is empty, SPAWN writes nothing.
- GRID_SPAWN_EN undefined: no LFSR, no SPAWN state; software places new tiles through wr_en.

## Test plan
- Reset, then wr row0 = [2,2,2,2], move left. Expect row0 = [4,4,0,0], score_delta = 8, moved = 1, done at cycle 14 after acceptance.
- Row0 = [4,2,2,0], move right. Expect row0 = [0,0,4,4], delta = 4. Column 1 = [2,0,2,8] (rows 0..3), move up. Expect col 1 = [4,8,0,0].
- Row0 = [16'h8000,16'h8000,0,0], move left. Expect unchanged, moved = 0, delta = 0.
- Load a full checkerboard of 2/4, any move. Expect moved = 0 and win_lose = 2'b10. Then clr: grid all 0 and win_lose = 0.
- Row0 = [1024,1024,0,0], move left. Expect win_lose[0] = 1. A wr_en asserted while busy leaves the grid unchanged. Reset at cycle 5 of a move gives all-zero outputs on the next cycle.
- GRID_SPAWN_EN, after a moving command: exactly one new tile appears, of value 2 or 4, in a previously empty cell, and done arrives at cycle 15. After a non-moving command no tile is added.
